// File: rtl/cone_eval_sequencer.sv
// rtl/cone_eval_sequencer.sv - round-robin sequencer sharing one combinational cone among requesters
// Holds the cone inputs in a register for SETTLE cycles, samples the output and returns it tagged.
module cone_eval_sequencer #(
    parameter int NREQ   = 4,
    parameter int IN_W   = 14,
    parameter int SETTLE = 2,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_vec,
    output logic [NREQ-1:0]      req_ready,
    output logic [IN_W-1:0]      cone_in,
    input  logic                 cone_out,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   rr_ptr_next;
    logic              found;
    logic [IN_W-1:0]   sel_vec;
    logic [3:0]        cnt;

    // Two passes: first the requesters at or above rr_ptr, then wrap to the lowest set bit.
    always_comb begin : arbitrate
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin : select_vec
        sel_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_vec = req_vec[i*IN_W +: IN_W];
            end
        end
    end

    assign rr_ptr_next = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is gated by rst_n so no accept strobe appears while reset is held.
    always_comb begin : fsm_next
        state_next = state;
        req_ready  = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready  = rst_n ? (NREQ'(1) << winner) : '0;
                    state_next = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cone_in   <= '0;
            cur_id    <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cone_in <= sel_vec;
                        cur_id  <= winner;
                        rr_ptr  <= rr_ptr_next;
                        cnt     <= 4'(SETTLE - 1);
                    end
                end
                SETTLE_WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= cone_out;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
